store_buffer_unit: RTL and testbench

Parametrised successor to the combinational store-data formatter. It accepts store requests from the execute stage and formats SB/SH/SW (and SD when XLEN=64) into a lane-aligned word with byte strobes. Formatted stores are queued in a DEPTH-entry FIFO and drained to data memory over a valid/ready write channel. It sits between execute and the data-memory port; `st_empty` gates fences.

---
 rtl/store_buffer_unit_pkg.sv | 26 ++
 rtl/store_fifo.sv | 52 +++++
 rtl/store_buffer_unit.sv | 152 +++++++++++++++
 tb/tb_store_buffer_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_unit_pkg.sv
// Store encodings and formatting helpers shared by store_buffer_unit and its FIFO.
package store_buffer_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic {StIdle, StSplit} sb_state_e;

    // Contiguous byte mask of the access size, anchored at lane 0.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   size_mask = 8'h01;
            F3_SH:   size_mask = 8'h03;
            F3_SW:   size_mask = 8'h0f;
            F3_SD:   size_mask = 8'hff;
            default: size_mask = 8'h00;
        endcase
    endfunction

    function automatic int unsigned strb_width(input int unsigned xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous FIFO with occupancy count; head reads as zero while empty.
module store_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; rdata is masked by empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/store_buffer_unit.sv
// Store formatter + write FIFO between execute and the data-memory write channel.
// Define STORE_SPLIT_MISALIGNED_EN to split word-crossing misaligned stores into two beats.
module store_buffer_unit
    import store_buffer_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [2:0]               st_funct3,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [XLEN-1:0]          st_data,
    output logic                     st_err,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_wstrb,
    output logic [$clog2(DEPTH):0]   st_count,
    output logic                     st_empty
);

    localparam int unsigned NB   = strb_width(XLEN);
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned EW   = ADDR_W + XLEN + NB;

    logic [OFFW-1:0]   off;
    logic [NB-1:0]     smask;
    logic [XLEN-1:0]   sdata;
    logic [ADDR_W-1:0] waddr;
    logic              illegal, misaligned, accept;
    logic              full, empty, push, pop;
    logic              err_q, err_d;
    logic [EW-1:0]     push_entry, head;

    assign off     = st_addr[OFFW-1:0];
    assign smask   = NB'(size_mask(st_funct3));
    assign waddr   = {st_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign illegal = st_funct3[2] | ((st_funct3 == F3_SD) & (XLEN == 32));

    // Drop rs2 bytes beyond the access size so unused lanes go out as zero.
    always_comb begin
        sdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (smask[i]) sdata[8*i +: 8] = st_data[8*i +: 8];
        end
    end

    always_comb begin
        case (st_funct3)
            F3_SH:   misaligned = off[0];
            F3_SW:   misaligned = |off[1:0];
            F3_SD:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

`ifdef STORE_SPLIT_MISALIGNED_EN
    logic [2*XLEN-1:0] data_w;
    logic [2*NB-1:0]   strb_w;
    logic              crosses;
    sb_state_e         state_q, state_d;
    logic [EW-1:0]     beat2_q, beat2_d;

    // Double-width shift: upper half is whatever spills into the next word.
    assign data_w  = {{XLEN{1'b0}}, sdata} << {off, 3'b000};
    assign strb_w  = {{NB{1'b0}}, smask} << off;
    assign crosses = misaligned & (|strb_w[2*NB-1:NB]);
    assign accept  = st_valid & st_ready;
    assign err_d   = accept & illegal;
    assign st_empty = empty & (state_q == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat2_q <= '0;
        end else begin
            state_q <= state_d;
            beat2_q <= beat2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat2_d = beat2_q;
        case (state_q)
            StIdle: begin
                if (accept && !illegal && crosses) begin
                    state_d = StSplit;
                    beat2_d = {waddr + ADDR_W'(NB), data_w[2*XLEN-1:XLEN], strb_w[2*NB-1:NB]};
                end
            end
            StSplit: if (!full) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        st_ready   = 1'b0;
        push       = 1'b0;
        push_entry = {waddr, data_w[XLEN-1:0], strb_w[NB-1:0]};
        case (state_q)
            StIdle: begin
                st_ready = ~rst & ~full;
                push     = st_valid & st_ready & ~illegal;
            end
            StSplit: begin
                push       = ~full;
                push_entry = beat2_q;
            end
            default: ;
        endcase
    end
`else
    assign st_ready   = ~rst & ~full;
    assign accept     = st_valid & st_ready;
    assign push       = accept & ~illegal & ~misaligned;
    assign push_entry = {waddr, XLEN'(sdata << {off, 3'b000}), NB'(smask << off)};
    assign err_d      = accept & (illegal | misaligned);
    assign st_empty   = empty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign st_err     = err_q;
    assign mem_wvalid = ~empty;
    assign pop        = mem_wvalid & mem_wready;
    assign {mem_waddr, mem_wdata, mem_wstrb} = head;

    store_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (st_count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_store_buffer_unit.sv
// Self-checking bench for store_buffer_unit: byte-level reference model plus directed vectors.
module tb_store_buffer_unit;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int NBY    = XLEN / 8;
`ifdef STORE_SPLIT_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              st_valid, st_ready, st_err;
    logic [2:0]        st_funct3;
    logic [ADDR_W-1:0] st_addr;
    logic [XLEN-1:0]   st_data;
    logic              mem_wvalid, mem_wready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NBY-1:0]    mem_wstrb;
    logic [$clog2(DEPTH):0] st_count;
    logic              st_empty;

    always #5 clk = ~clk;

    store_buffer_unit #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_funct3  (st_funct3),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_err     (st_err),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .st_count   (st_count),
        .st_empty   (st_empty)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t exp_q[$];
    bit   pend;
    ent_t pend_e;
    bit   err_exp;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] f3);
        return f3[2] || (f3 == 3'b011 && XLEN == 32);
    endfunction

    // Walk every byte of the store and drop it into the word and lane it addresses.
    function automatic void make_beats(input logic [31:0] a, input logic [31:0] d,
                                       input int size, output ent_t b0, output ent_t b1,
                                       output int nb);
        logic [31:0] base, ba;
        int lane;
        base = a & ~32'(NBY - 1);
        b0 = '0;
        b1 = '0;
        nb = 1;
        b0.addr = base;
        b1.addr = base + 32'(NBY);
        for (int k = 0; k < size; k++) begin
            ba = a + 32'(k);
            lane = int'(ba % 32'(NBY));
            if ((ba & ~32'(NBY - 1)) == base) begin
                b0.data[8*lane +: 8] = d[8*k +: 8];
                b0.strb[lane] = 1'b1;
            end else begin
                b1.data[8*lane +: 8] = d[8*k +: 8];
                b1.strb[lane] = 1'b1;
                nb = 2;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit   full_m, acc;
        int   size, nb;
        ent_t b0, b1;
        if (rst) begin
            exp_q.delete();
            pend    = 1'b0;
            err_exp = 1'b0;
        end else begin
            full_m  = exp_q.size() >= DEPTH;
            acc     = st_valid && !full_m && !pend;
            size    = 1 << st_funct3[1:0];
            err_exp = 1'b0;
            if (exp_q.size() > 0 && mem_wready) void'(exp_q.pop_front());
            if (pend && !full_m) begin
                exp_q.push_back(pend_e);
                pend = 1'b0;
            end else if (acc) begin
                if (is_illegal(st_funct3)) begin
                    err_exp = 1'b1;
                end else if ((st_addr % 32'(size)) != 0 && !SPLIT_EN) begin
                    err_exp = 1'b1;
                end else begin
                    make_beats(st_addr, st_data, size, b0, b1, nb);
                    exp_q.push_back(b0);
                    if (nb == 2) begin
                        pend   = 1'b1;
                        pend_e = b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("st_ready", st_ready, (exp_q.size() < DEPTH) && !pend);
            check("st_count", st_count, exp_q.size());
            check("st_empty", st_empty, (exp_q.size() == 0) && !pend);
            check("st_err", st_err, err_exp);
            check("mem_wvalid", mem_wvalid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("mem_waddr", mem_waddr, exp_q[0].addr);
                check("mem_wdata", mem_wdata, exp_q[0].data);
                check("mem_wstrb", mem_wstrb, exp_q[0].strb);
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit r;
        int n;
        n = 0;
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        do begin
            @(negedge clk);
            r = st_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: st_ready stayed 0, expected 1 within 100 cycles");
        end
        st_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        st_valid = 1'b0; st_funct3 = '0; st_addr = '0; st_data = '0; mem_wready = 1'b0;
        #1;
        check("rst_ready", st_ready, 0);
        check("rst_wvalid", mem_wvalid, 0);
        check("rst_count", st_count, 0);
        check("rst_empty", st_empty, 1);
        check("rst_err", st_err, 0);
        check("rst_head", {mem_waddr, mem_wdata}, 0);
        check("rst_strb", mem_wstrb, 0);
        idle(2);
        rst = 1'b0;
        mem_wready = 1'b1;

        send(3'b010, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("sw_waddr", mem_waddr, 32'h100);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_wstrb", mem_wstrb, 4'hF);
        idle(1);
        @(negedge clk);
        check("sw_drained", st_count, 0);

        send(3'b000, 32'h203, 32'h000000A5);
        @(negedge clk);
        check("sb_wdata", mem_wdata, 32'hA5000000);
        check("sb_wstrb", mem_wstrb, 4'h8);
        send(3'b001, 32'h202, 32'h00001234);
        @(negedge clk);
        check("sh_wdata", mem_wdata, 32'h12340000);
        check("sh_wstrb", mem_wstrb, 4'hC);
        send(3'b000, 32'h201, 32'h123456A5);
        @(negedge clk);
        check("sb_mask_wdata", mem_wdata, 32'h0000A500);
        check("sb_mask_wstrb", mem_wstrb, 4'h2);
        idle(2);

        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'b010, 32'h300 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
        @(negedge clk);
        check("full_count", st_count, 4);
        check("full_ready", st_ready, 0);
        fork
            send(3'b010, 32'h310, 32'h55555555);
            begin
                idle(3);
                check("stall_count", st_count, 4);
                check("stall_head", mem_waddr, 32'h300);
                mem_wready = 1'b1;
            end
        join
        idle(8);

        send(3'b010, 32'h101, 32'hAABBCCDD);
        @(negedge clk);
        if (SPLIT_EN) begin
            check("split_b1_addr", mem_waddr, 32'h100);
            check("split_b1_data", mem_wdata, 32'hBBCCDD00);
            check("split_b1_strb", mem_wstrb, 4'hE);
            idle(1);
            @(negedge clk);
            check("split_b2_addr", mem_waddr, 32'h104);
            check("split_b2_data", mem_wdata, 32'h000000AA);
            check("split_b2_strb", mem_wstrb, 4'h1);
        end else begin
            check("misalign_err", st_err, 1);
            check("misalign_count", st_count, 0);
        end
        idle(2);
        send(3'b001, 32'h201, 32'h0000BEEF);
        send(3'b001, 32'h203, 32'h0000C0DE);
        idle(4);

        send(3'b011, 32'h8, 32'h01234567);
        @(negedge clk);
        check("sd_x32_err", st_err, 1);
        check("sd_x32_count", st_count, 0);
        send(3'b100, 32'h8, 32'h01234567);
        @(negedge clk);
        check("f3_1xx_err", st_err, 1);
        idle(2);

        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'b010, 32'h500 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wvalid", mem_wvalid, 0);
        check("midrst_count", st_count, 0);
        check("midrst_empty", st_empty, 1);
        check("midrst_ready", st_ready, 0);
        idle(2);
        rst = 1'b0;
        mem_wready = 1'b1;
        send(3'b010, 32'h400, 32'hCAFEF00D);
        @(negedge clk);
        check("post_rst_waddr", mem_waddr, 32'h400);
        check("post_rst_wdata", mem_wdata, 32'hCAFEF00D);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
